// File: rtl/ped_crossing_pkg.sv
// Shared types for the pedestrian crossing controller: state codes and lamp patterns.
package ped_crossing_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RGREEN  = 3'd0,
        S_RYELLOW = 3'd1,
        S_ALLRED1 = 3'd2,
        S_PGREEN  = 3'd3,
        S_PFLASH  = 3'd4,
        S_ALLRED2 = 3'd5,
        S_RREDYEL = 3'd6
    } state_t;

    typedef struct packed {
        logic road_r;
        logic road_y;
        logic road_g;
        logic ped_r;
        logic ped_g;
    } lamps_t;

    localparam lamps_t L_RGREEN  = 5'b00110;
    localparam lamps_t L_RYELLOW = 5'b01010;
    localparam lamps_t L_ALLRED  = 5'b10010;
    localparam lamps_t L_PGREEN  = 5'b10001;
    localparam lamps_t L_PDARK   = 5'b10000;
    localparam lamps_t L_RREDYEL = 5'b11010;

    function automatic lamps_t lamps_of(state_t s, logic flash);
        lamps_t l;
        case (s)
            S_RGREEN:  l = L_RGREEN;
            S_RYELLOW: l = L_RYELLOW;
            S_PGREEN:  l = L_PGREEN;
            S_PFLASH:  l = flash ? L_PGREEN : L_PDARK;
            S_RREDYEL: l = L_RREDYEL;
            default:   l = L_ALLRED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Detector/button inputs and lamp/status outputs of the crossing controller.
interface ped_crossing_ctrl_if;
    import ped_crossing_pkg::*;

    logic               ROAD_DET;
    logic               PED_BUTT;
    logic               ROAD_RED;
    logic               ROAD_YELLOW;
    logic               ROAD_GREEN;
    logic               PED_RED;
    logic               PED_GREEN;
    logic               PED_WAIT;
    logic [STATE_W-1:0] STATE;

    // controller side
    modport master (
        input  ROAD_DET, PED_BUTT,
        output ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN, PED_WAIT, STATE
    );

    // street side: detectors drive in, lamps observed
    modport slave (
        output ROAD_DET, PED_BUTT,
        input  ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN, PED_WAIT, STATE
    );

endinterface

// File: rtl/ped_tick_gen.sv
// Free-running divider producing a one-CLK TICK every TICK_DIV cycles.
module ped_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic nRST,
    output logic TICK
);
    localparam int DW = $clog2(TICK_DIV);

    if (TICK_DIV < 2) begin : g_param_chk
        $error("ped_tick_gen: TICK_DIV must be >= 2");
    end

    logic [DW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!nRST)                         cnt <= '0;
        else if (cnt == DW'(TICK_DIV - 1)) cnt <= '0;
        else                               cnt <= cnt + 1'b1;
    end

    assign TICK = (cnt == DW'(TICK_DIV - 1));

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller with vehicle-actuated green extension.
// Define PED_CROSSING_FLASH_EN to include the flashing pedestrian-green phase.
module ped_crossing_ctrl
    import ped_crossing_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int CNT_W        = 8,
    parameter int T_MIN_GREEN  = 10,
    parameter int T_EXT_MAX    = 5,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 2,
    parameter int T_RED_YELLOW = 2,
    parameter int T_PED_GREEN  = 8,
    parameter int T_PED_FLASH  = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    ped_crossing_ctrl_if.master xing
);
    localparam int TMAX = 2**CNT_W;

    if (T_MIN_GREEN < 1 || T_MIN_GREEN >= TMAX || T_EXT_MAX < 1 || T_EXT_MAX >= TMAX ||
        T_YELLOW < 1 || T_YELLOW >= TMAX || T_ALL_RED < 1 || T_ALL_RED >= TMAX ||
        T_RED_YELLOW < 1 || T_RED_YELLOW >= TMAX || T_PED_GREEN < 1 || T_PED_GREEN >= TMAX ||
        T_PED_FLASH < 1 || T_PED_FLASH >= TMAX) begin : g_param_chk
        $error("ped_crossing_ctrl: phase durations must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] D_MING = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] D_EXT  = CNT_W'(T_EXT_MAX - 1);
    localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] D_AR   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] D_RY   = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] D_PG   = CNT_W'(T_PED_GREEN - 1);
`ifdef PED_CROSSING_FLASH_EN
    localparam logic [CNT_W-1:0] D_PF   = CNT_W'(T_PED_FLASH - 1);
`endif

    logic tick;

    ped_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK  (CLK),
        .nRST (nRST),
        .TICK (tick)
    );

    logic [2:0] butt_sr;
    logic [1:0] det_sr;
    logic       butt_edge, det;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt, ext_cnt, ext_cnt_nxt;
    logic             ext_on, ext_on_nxt, flash, flash_nxt, req, req_nxt, entry;
    lamps_t           lamps_q;

    assign butt_edge = butt_sr[1] & ~butt_sr[2];
    assign det       = det_sr[1];

    always_comb begin
        state_nxt   = state;
        ext_on_nxt  = ext_on;
        ext_cnt_nxt = ext_cnt;
        case (state)
            S_RGREEN: if (tick) begin
                // once extending, the minimum-green test no longer applies
                if (ext_on) begin
                    if (!det || ext_cnt == D_EXT) state_nxt   = S_RYELLOW;
                    else                          ext_cnt_nxt = ext_cnt + 1'b1;
                end else if (req && timer >= D_MING) begin
                    if (det) ext_on_nxt = 1'b1;
                    else     state_nxt  = S_RYELLOW;
                end
            end
            S_RYELLOW: if (tick && timer == D_YEL) state_nxt = S_ALLRED1;
            S_ALLRED1: if (tick && timer == D_AR)  state_nxt = S_PGREEN;
`ifdef PED_CROSSING_FLASH_EN
            S_PGREEN:  if (tick && timer == D_PG)  state_nxt = S_PFLASH;
            S_PFLASH:  if (tick && timer == D_PF)  state_nxt = S_ALLRED2;
`else
            S_PGREEN:  if (tick && timer == D_PG)  state_nxt = S_ALLRED2;
`endif
            S_ALLRED2: if (tick && timer == D_AR)  state_nxt = S_RREDYEL;
            S_RREDYEL: if (tick && timer == D_RY)  state_nxt = S_RGREEN;
            default:                               state_nxt = S_RGREEN;
        endcase

        entry = (state_nxt != state);
        if (entry) begin
            ext_on_nxt  = 1'b0;
            ext_cnt_nxt = '0;
        end

        timer_nxt = timer;
        if (entry)                    timer_nxt = '0;
        else if (tick && timer != '1) timer_nxt = timer + 1'b1;

        flash_nxt = flash;
        if (entry)                         flash_nxt = 1'b1;
        else if (tick && state == S_PFLASH) flash_nxt = ~flash;

        // clearing on entry to pedestrian green beats an edge in the same cycle
        req_nxt = req;
        if (entry && state_nxt == S_PGREEN)                       req_nxt = 1'b0;
        else if (butt_edge && state != S_PGREEN && state != S_PFLASH) req_nxt = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            butt_sr <= '0;
            det_sr  <= '0;
            state   <= S_RGREEN;
            timer   <= '0;
            ext_on  <= 1'b0;
            ext_cnt <= '0;
            flash   <= 1'b0;
            req     <= 1'b0;
            lamps_q <= L_RGREEN;
        end else begin
            butt_sr <= {butt_sr[1:0], xing.PED_BUTT};
            det_sr  <= {det_sr[0], xing.ROAD_DET};
            state   <= state_nxt;
            timer   <= timer_nxt;
            ext_on  <= ext_on_nxt;
            ext_cnt <= ext_cnt_nxt;
            flash   <= flash_nxt;
            req     <= req_nxt;
            lamps_q <= lamps_of(state, flash);
        end
    end

    assign xing.ROAD_RED    = lamps_q.road_r;
    assign xing.ROAD_YELLOW = lamps_q.road_y;
    assign xing.ROAD_GREEN  = lamps_q.road_g;
    assign xing.PED_RED     = lamps_q.ped_r;
    assign xing.PED_GREEN   = lamps_q.ped_g;
    assign xing.PED_WAIT    = req;
    assign xing.STATE       = state;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: scoreboarded phase sequence plus extension-timing table.
module tb_ped_crossing_ctrl;

    typedef struct {
        logic [2:0] st;
        int         cyc;
        logic [4:0] lamps;
        logic       wt;
    } phase_t;

    typedef struct {
        int det_cycles;
        int exp_green;
    } ext_vec_t;

`ifdef PED_CROSSING_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ped_crossing_ctrl_if xing();

    ped_crossing_ctrl #(
        .TICK_DIV(4), .CNT_W(8), .T_MIN_GREEN(3), .T_EXT_MAX(2), .T_YELLOW(2),
        .T_ALL_RED(2), .T_RED_YELLOW(2), .T_PED_GREEN(2), .T_PED_FLASH(2)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .xing (xing)
    );

    int       n_vec = 0, n_err = 0;
    phase_t   seq_tab[$];
    phase_t   sb[$];
    ext_vec_t ext_tab[3];
    bit       mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] lamps();
        return {xing.ROAD_RED, xing.ROAD_YELLOW, xing.ROAD_GREEN, xing.PED_RED, xing.PED_GREEN};
    endfunction

    // monitor: every STATE change pops one expected phase record
    logic [2:0] prev_st;
    int         dwell, cur_cyc;
    bit         lamp_pend, seen4 = 1'b0;
    logic [4:0] exp_lamps;
    phase_t     e;

    always @(negedge CLK) begin
        if (!mon_en) begin
            prev_st   = xing.STATE;
            dwell     = 0;
            cur_cyc   = 0;
            lamp_pend = 1'b0;
        end else begin
            if (xing.STATE == 3'd4) seen4 = 1'b1;
            if (lamp_pend) begin
                check("lamps", 32'(lamps()), 32'(exp_lamps));
                lamp_pend = 1'b0;
            end
            dwell++;
            if (xing.STATE != prev_st) begin
                if (cur_cyc != 0) check("dwell", dwell, cur_cyc);
                if (sb.size() == 0) begin
                    check("unexpected_state", 32'(xing.STATE), 32'(prev_st));
                end else begin
                    e = sb.pop_front();
                    check("state", 32'(xing.STATE), 32'(e.st));
                    check("wait_on_entry", 32'(xing.PED_WAIT), 32'(e.wt));
                    cur_cyc   = e.cyc;
                    exp_lamps = e.lamps;
                    lamp_pend = 1'b1;
                end
                prev_st = xing.STATE;
                dwell   = 0;
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic push_seq();
        foreach (seq_tab[i]) sb.push_back(seq_tab[i]);
    endtask

    task automatic do_reset(int n);
        mon_en = 1'b0;
        sb.delete();
        nRST = 1'b0;
        repeat (n) step();
        check("rst_state", 32'(xing.STATE), 0);
        check("rst_lamps", 32'(lamps()), 32'h06);
        check("rst_wait", 32'(xing.PED_WAIT), 0);
        nRST   = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic press();
        xing.PED_BUTT = 1'b1;
        repeat (3) step();
        xing.PED_BUTT = 1'b0;
    endtask

    task automatic wait_state(string name, logic [2:0] s, int budget);
        for (int i = 0; i < budget && xing.STATE != s; i++) step();
        check(name, 32'(xing.STATE), 32'(s));
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget && !(sb.size() == 0 && xing.STATE == 3'd0); i++) step();
        check("idle_sb", sb.size(), 0);
        check("idle_state", 32'(xing.STATE), 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        xing.ROAD_DET = 1'b0;
        xing.PED_BUTT = 1'b0;

        seq_tab.push_back('{3'd1, 8, 5'b01010, 1'b1});
        seq_tab.push_back('{3'd2, 8, 5'b10010, 1'b1});
        seq_tab.push_back('{3'd3, 8, 5'b10001, 1'b0});
        if (FLASH) seq_tab.push_back('{3'd4, 8, 5'b10001, 1'b0});
        seq_tab.push_back('{3'd5, 8, 5'b10010, 1'b0});
        seq_tab.push_back('{3'd6, 8, 5'b11010, 1'b0});
        seq_tab.push_back('{3'd0, 0, 5'b00110, 1'b0});

        ext_tab[0] = '{0, 12};
        ext_tab[1] = '{13, 16};
        ext_tab[2] = '{1000, 20};

        // reset, then no button: road stays green
        do_reset(5);
        repeat (40) step();
        check("idle_green_state", 32'(xing.STATE), 0);
        check("idle_green_lamps", 32'(lamps()), 32'h06);

        // single press around cycle 10: one full crossing
        do_reset(5);
        repeat (9) step();
        push_seq();
        xing.PED_BUTT = 1'b1;
        n = 0;
        while (n < 8 && !xing.PED_WAIT) begin
            step();
            n++;
            if (n == 3) xing.PED_BUTT = 1'b0;
        end
        xing.PED_BUTT = 1'b0;
        check("wait_set", 32'(xing.PED_WAIT), 1);
        wait_idle(300);
        check("wait_clear_after", 32'(xing.PED_WAIT), 0);

        // press during pedestrian green is ignored
        push_seq();
        press();
        wait_state("reach_pgreen", 3'd3, 150);
        press();
        repeat (2) step();
        check("pg_press_state", 32'(xing.STATE), 3);
        check("pg_press_wait", 32'(xing.PED_WAIT), 0);
        wait_idle(200);
        repeat (60) step();
        check("no_second_cycle", 32'(xing.STATE), 0);
        check("no_second_wait", 32'(xing.PED_WAIT), 0);

        // green length vs detector, request pending from reset release
        foreach (ext_tab[k]) begin
            do_reset(3);
            xing.ROAD_DET = (ext_tab[k].det_cycles > 0);
            xing.PED_BUTT = 1'b1;
            push_seq();
            n = 0;
            while (n < 60 && xing.STATE != 3'd1) begin
                step();
                n++;
                if (n == 3) xing.PED_BUTT = 1'b0;
                if (n == ext_tab[k].det_cycles) xing.ROAD_DET = 1'b0;
            end
            xing.ROAD_DET = 1'b0;
            xing.PED_BUTT = 1'b0;
            check($sformatf("green_cycles_%0d", k), n, ext_tab[k].exp_green);
            wait_idle(200);
        end

        // reset in the middle of the pedestrian phase
        push_seq();
        press();
        wait_state("reach_ped_phase", FLASH ? 3'd4 : 3'd3, 150);
        step();
        mon_en = 1'b0;
        sb.delete();
        nRST = 1'b0;
        step();
        check("abort_state", 32'(xing.STATE), 0);
        check("abort_road_green", 32'(xing.ROAD_GREEN), 1);
        check("abort_ped_red", 32'(xing.PED_RED), 1);
        check("abort_ped_green", 32'(xing.PED_GREEN), 0);
        check("abort_wait", 32'(xing.PED_WAIT), 0);
        nRST   = 1'b1;
        mon_en = 1'b1;
        repeat (60) step();
        check("abort_no_resume", 32'(xing.STATE), 0);

        check("flash_state_seen", 32'(seen4), 32'(FLASH));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ped_crossing_ctrl.md
PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, CLK cycles per timing tick (>=2).
REQ-002 SHALL have parameter CNT_W, default 8, phase-timer width in bits.
REQ-003 SHALL have parameters T_MIN_GREEN=10, T_EXT_MAX=5, T_YELLOW=3, T_ALL_RED=2, T_RED_YELLOW=2, T_PED_GREEN=8, T_PED_FLASH=4, all phase durations in ticks, each >=1 and <2**CNT_W.
REQ-004 SHALL have port CLK, input, 1, single system clock.
REQ-005 SHALL have port nRST, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port ROAD_DET, input, 1, asynchronous vehicle-detector level.
REQ-007 SHALL have port PED_BUTT, input, 1, asynchronous pedestrian-button level, active-high.
REQ-008 SHALL have ports ROAD_RED, ROAD_YELLOW, ROAD_GREEN, outputs, 1 each, road lamps, active-high.
REQ-009 SHALL have ports PED_RED, PED_GREEN, outputs, 1 each, pedestrian lamps, active-high.
REQ-010 SHALL have port PED_WAIT, output, 1, high while a pedestrian request is pending.
REQ-011 SHALL have port STATE, output, 3, current FSM state code.

Function
REQ-012 SHALL double-flop-synchronise ROAD_DET and PED_BUTT; button request = rising edge of synchronised PED_BUTT.
REQ-013 SHALL generate a one-CLK tick pulse every TICK_DIV cycles from a free-running divider; all timing advances only on ticks.
REQ-014 SHALL implement states: S_RGREEN(0), S_RYELLOW(1), S_ALLRED1(2), S_PGREEN(3), S_PFLASH(4), S_ALLRED2(5), S_RREDYEL(6).
REQ-015 SHALL clear the phase timer on every state entry and increment it on each tick; phase of duration D ends on the tick where timer==D-1.
REQ-016 S_RGREEN SHALL hold until timer>=T_MIN_GREEN-1 on a tick with request pending; if synced ROAD_DET is high then, green extends by up to T_EXT_MAX further ticks, leaving early on the first tick with ROAD_DET low.
REQ-017 Sequence SHALL be S_RGREEN->S_RYELLOW->S_ALLRED1->S_PGREEN->S_PFLASH->S_ALLRED2->S_RREDYEL->S_RGREEN, each non-green phase lasting its parameter.
REQ-018 Lamps SHALL be: RGREEN road G/ped R; RYELLOW road Y/ped R; ALLRED1, ALLRED2 road R/ped R; PGREEN road R/ped G; PFLASH road R/ped G toggling each tick starting high; RREDYEL road R+Y/ped R.
REQ-019 Request latch SHALL set on button edge in any state except S_PGREEN/S_PFLASH, clear on entry to S_PGREEN; edge on the entry cycle is discarded.
REQ-020 Timer SHALL saturate at 2**CNT_W-1, never wrap.
REQ-021 All outputs SHALL be registered; lamp change lags state change by one CLK.

Reset
REQ-022 While nRST low at a CLK edge: state S_RGREEN, timer 0, divider 0, request latch 0, sync flops 0.
REQ-023 Output reset values: ROAD_GREEN=1, PED_RED=1, all other lamps 0, PED_WAIT=0, STATE=0.
REQ-024 Reset mid-phase SHALL abort immediately with no partial sequence on release.

Configuration
REQ-025 Macro PED_CROSSING_FLASH_EN defined: S_PFLASH present per REQ-017/018.
REQ-026 Macro undefined: S_PGREEN goes directly to S_ALLRED2; T_PED_FLASH unused; STATE code 4 never produced.

Structure
REQ-027 Shared package ped_crossing_pkg SHALL hold the state enum, STATE width, and lamp-vector constants per state.
REQ-028 Tick divider SHALL be sub-module ped_tick_gen (parameter TICK_DIV; ports CLK, nRST, TICK).

Verification (TICK_DIV=4, T_MIN_GREEN=3, T_EXT_MAX=2, others 2)
REQ-029 Reset held 5 cycles, no button -> ROAD_GREEN=1, PED_RED=1 indefinitely, STATE=0.
REQ-030 Button pulse at cycle 10 -> PED_WAIT=1 two cycles later; full sequence 0,1,2,3,4,5,6,0 with each phase 8 cycles; PED_WAIT drops on entry to 3.
REQ-031 Button pending, ROAD_DET held high -> green lasts exactly 3+2 ticks; ROAD_DET dropping after 1 extension tick -> exit on that tick.
REQ-032 Button pressed during S_PGREEN -> PED_WAIT stays 0, no second cycle.
REQ-033 nRST asserted during S_PFLASH -> next cycle STATE=0, road green, PED_WAIT=0.
REQ-034 Build without PED_CROSSING_FLASH_EN -> STATE goes 3->5, never 4.
